// File: rtl/vga_timing_pkg.sv
// Mode constants and helpers shared by the VGA raster timing generator.
// A mode is four region lengths per axis plus the sync polarity.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } axis_mode_t;

  typedef struct packed {
    axis_mode_t h;
    axis_mode_t v;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0},
    v: '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0}
  };

  localparam vga_mode_t MODE_800x600_60 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1},
    v: '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1}
  };

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with active/sync region decode.
// Regions run active, front porch, sync, back porch.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int unsigned W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_active,
  output logic         in_sync
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_region
    $error("vga_axis_counter: every region length must be non-zero");
  end

  // A sync pulse wider than the visible span is not a meaningful raster mode.
  if (SYNC > ACTIVE) begin : g_sync_too_wide
    $error("vga_axis_counter: SYNC exceeds the visible span");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  assign wrap      = inc && (count == LAST);
  assign in_active = (count < ACT_END);
  assign in_sync   = (count >= SYNC_LO) && (count < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Outputs are registered one enabled clock after the h/v counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_640x480_60.h.active,
  parameter int unsigned H_FP     = MODE_640x480_60.h.fp,
  parameter int unsigned H_SYNC   = MODE_640x480_60.h.sync,
  parameter int unsigned H_BP     = MODE_640x480_60.h.bp,
  parameter int unsigned V_ACTIVE = MODE_640x480_60.v.active,
  parameter int unsigned V_FP     = MODE_640x480_60.v.fp,
  parameter int unsigned V_SYNC   = MODE_640x480_60.v.sync,
  parameter int unsigned V_BP     = MODE_640x480_60.v.bp,
  parameter logic        HS_POL   = MODE_640x480_60.h.pol,
  parameter logic        VS_POL   = MODE_640x480_60.v.pol,
  parameter int unsigned FRAME_W  = 8,
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [HW-1:0]      x,
  output logic [VW-1:0]      y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  if (FRAME_W == 0) begin : g_bad_frame_w
    $error("vga_timing_gen: FRAME_W must be non-zero");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, h_act, h_sync;
  logic          v_wrap, v_act, v_sync;
  logic          h_zero, v_zero;
  logic          frame_done;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst(rst), .inc(pix_ce),
    .count(h_cnt), .wrap(h_wrap), .in_active(h_act), .in_sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst(rst), .inc(h_wrap),
    .count(v_cnt), .wrap(v_wrap), .in_active(v_act), .in_sync(v_sync)
  );

  assign h_zero = (h_cnt == '0);
  assign v_zero = (v_cnt == '0);

  // Output stage: decode of current h/v, captured on enabled clocks only.
  // frame_done remembers a completed frame so the first frame after reset is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_zero;
      frame_start <= pix_ce && h_zero && v_zero;
      if (v_wrap) begin
        frame_done <= 1'b1;
      end
      if (pix_ce) begin
        x     <= h_cnt;
        y     <= v_cnt;
        de    <= h_act && v_act;
        hsync <= h_sync ? HS_POL : ~HS_POL;
        vsync <= v_sync ? VS_POL : ~VS_POL;
        if (h_zero && v_zero && frame_done) begin
          frame_cnt  <= frame_cnt + FRAME_W'(1);
          frame_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny mode, both
// checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic pix_ce;

  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [2:0] s_x, s_y;
  logic [7:0] s_fc;

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_W(8)
  ) u_small (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  int     errors = 0;
  int     checks = 0;
  longint ticks  = 0;
  bit     last_ce = 1'b0;

  typedef struct {
    int x, y;
    bit hs, vs, de, ls, fs;
    int fc;
  } obs_t;

  typedef struct {
    bit ce;
    int x, y;
    bit hs, de, ls, fs;
  } vec_t;

  vec_t tbl[12];

  // Outputs after tk enabled edges since reset: the raster position is simply tk-1 pixels in.
  function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp, input longint tk, input bit lce);
    obs_t   o;
    longint p, line;
    int     ht, vt, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (tk == 0) begin
      o.x = 0; o.y = 0; o.de = 0; o.hs = ~hp; o.vs = ~vp;
      o.ls = 0; o.fs = 0; o.fc = 0;
    end else begin
      p    = tk - 1;
      h    = int'(p % ht);
      line = p / ht;
      v    = int'(line % vt);
      o.x  = h;
      o.y  = v;
      o.de = (h < ha) && (v < va);
      o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
      o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
      o.ls = lce && (h == 0);
      o.fs = lce && (h == 0) && (v == 0);
      o.fc = int'((line / vt) % 256);
    end
    return o;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d, t=%0t)", name, act, exp, ticks, $time);
    end
  endtask

  task automatic check_all();
    obs_t o;
    o = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, ticks, last_ce);
    cmp("dflt.x", 32'(d_x), o.x);   cmp("dflt.y", 32'(d_y), o.y);
    cmp("dflt.hsync", 32'(d_hs), 32'(o.hs)); cmp("dflt.vsync", 32'(d_vs), 32'(o.vs));
    cmp("dflt.de", 32'(d_de), 32'(o.de));    cmp("dflt.line_start", 32'(d_ls), 32'(o.ls));
    cmp("dflt.frame_start", 32'(d_fs), 32'(o.fs)); cmp("dflt.frame_cnt", 32'(d_fc), o.fc);
    o = model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, ticks, last_ce);
    cmp("small.x", 32'(s_x), o.x);   cmp("small.y", 32'(s_y), o.y);
    cmp("small.hsync", 32'(s_hs), 32'(o.hs)); cmp("small.vsync", 32'(s_vs), 32'(o.vs));
    cmp("small.de", 32'(s_de), 32'(o.de));    cmp("small.line_start", 32'(s_ls), 32'(o.ls));
    cmp("small.frame_start", 32'(s_fs), 32'(o.fs)); cmp("small.frame_cnt", 32'(s_fc), o.fc);
  endtask

  task automatic step(input bit ce);
    @(negedge clk);
    pix_ce = ce;
    @(posedge clk);
    if (ce) ticks++;
    last_ce = ce;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_ce  = 1'b0;
    rst     = 1'b1;
    ticks   = 0;
    last_ce = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  first_ls, second_ls, hs_first, hs_cnt, de_cnt, ls_run, ls_max, n;
    bit  saw255, wrapped;

    tbl[0]  = '{ce:1, x:0, y:0, hs:0, de:1, ls:1, fs:1};
    tbl[1]  = '{ce:0, x:0, y:0, hs:0, de:1, ls:0, fs:0};
    tbl[2]  = '{ce:1, x:1, y:0, hs:0, de:1, ls:0, fs:0};
    tbl[3]  = '{ce:1, x:2, y:0, hs:0, de:1, ls:0, fs:0};
    tbl[4]  = '{ce:1, x:3, y:0, hs:0, de:1, ls:0, fs:0};
    tbl[5]  = '{ce:1, x:4, y:0, hs:0, de:0, ls:0, fs:0};
    tbl[6]  = '{ce:1, x:5, y:0, hs:1, de:0, ls:0, fs:0};
    tbl[7]  = '{ce:0, x:5, y:0, hs:1, de:0, ls:0, fs:0};
    tbl[8]  = '{ce:1, x:6, y:0, hs:1, de:0, ls:0, fs:0};
    tbl[9]  = '{ce:1, x:7, y:0, hs:0, de:0, ls:0, fs:0};
    tbl[10] = '{ce:1, x:0, y:1, hs:0, de:1, ls:1, fs:0};
    tbl[11] = '{ce:1, x:1, y:1, hs:0, de:1, ls:0, fs:0};

    rst    = 1'b1;
    pix_ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Hand-derived vectors for the small mode, including ce gaps.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ce);
      cmp($sformatf("tbl[%0d].x", i), 32'(s_x), tbl[i].x);
      cmp($sformatf("tbl[%0d].y", i), 32'(s_y), tbl[i].y);
      cmp($sformatf("tbl[%0d].hsync", i), 32'(s_hs), 32'(tbl[i].hs));
      cmp($sformatf("tbl[%0d].de", i), 32'(s_de), 32'(tbl[i].de));
      cmp($sformatf("tbl[%0d].line_start", i), 32'(s_ls), 32'(tbl[i].ls));
      cmp($sformatf("tbl[%0d].frame_start", i), 32'(s_fs), 32'(tbl[i].fs));
    end

    // Random sparse clock-enable.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0);

    // Asynchronous reset mid-line, asserted between clock edges.
    n = 0;
    while (d_x != 10'd300 && n < 1000) begin
      step(1'b1);
      n++;
    end
    cmp("reach_x300", 32'(d_x), 300);
    @(negedge clk);
    #2 rst = 1'b1;
    ticks   = 0;
    last_ce = 1'b0;
    #1;
    cmp("async.hsync", 32'(d_hs), 1); cmp("async.vsync", 32'(d_vs), 1);
    cmp("async.de", 32'(d_de), 0);    cmp("async.x", 32'(d_x), 0);
    cmp("async.y", 32'(d_y), 0);      cmp("async.frame_cnt", 32'(d_fc), 0);
    cmp("async.small_hsync", 32'(s_hs), 0);
    check_all();
    @(negedge clk);
    rst    = 1'b0;
    pix_ce = 1'b0;

    // Default line timing with pix_ce held high.
    first_ls = -1; second_ls = -1; hs_first = -1; hs_cnt = 0; de_cnt = 0;
    for (int i = 1; i <= 1700; i++) begin
      step(1'b1);
      if (i == 1) begin
        cmp("release.frame_start", 32'(d_fs), 1);
        cmp("release.de", 32'(d_de), 1);
      end
      if (d_ls) begin
        if (first_ls < 0) first_ls = i;
        else if (second_ls < 0) second_ls = i;
      end
      if (i <= 800) begin
        if (!d_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = i;
        end
        if (d_de) de_cnt++;
      end
    end
    cmp("line.first_ls", first_ls, 1);
    cmp("line.period", second_ls - first_ls, 800);
    cmp("line.hsync_start", hs_first, 657);
    cmp("line.hsync_width", hs_cnt, 96);
    cmp("line.de_width", de_cnt, 640);

    // Alternate-clock enable: line period doubles, pulses stay one clock wide.
    do_reset();
    first_ls = -1; second_ls = -1; ls_run = 0; ls_max = 0;
    for (int i = 0; i < 3400; i++) begin
      step(i % 2 == 0);
      if (d_ls) begin
        ls_run++;
        if (first_ls < 0) first_ls = i;
        else if (second_ls < 0) second_ls = i;
      end else begin
        ls_run = 0;
      end
      if (ls_run > ls_max) ls_max = ls_run;
    end
    cmp("alt.line_period", second_ls - first_ls, 1600);
    cmp("alt.ls_width", ls_max, 1);

    // pix_ce held low: everything frozen, pulses low.
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      cmp("freeze.line_start", 32'(d_ls), 0);
      cmp("freeze.frame_start", 32'(s_fs), 0);
    end

    // Small mode over 256+ frames: frame counter wraps 255 -> 0.
    do_reset();
    saw255 = 0; wrapped = 0;
    for (int i = 0; i < 12300; i++) begin
      step(1'b1);
      if (s_fc == 8'd255) saw255 = 1;
      if (saw255 && s_fc == 8'd0) wrapped = 1;
    end
    cmp("small.fc_reached_255", 32'(saw255), 1);
    cmp("small.fc_wrapped", 32'(wrapped), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
